// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the pipelined 16-bit TSC CPU. Owns the program
// counter, the request/response handshake to instruction memory and the IF/ID
// pipeline register. Sits directly upstream of decode/control.
//
// Ports
//   clk            clock, all state updates on posedge
//   reset_n        asynchronous active-low reset
//   i_readM        instruction memory read request
//   i_address      word address of the outstanding request (stable until
//                  i_ready)
//   i_data         instruction word, valid while i_ready=1
//   i_ready        single-cycle response strobe, one per request; may come
//                  in the same cycle as the request
//   stall          hazard unit: hold IF/ID and PC
//   redirect       taken branch/jump: flush IF/ID and refetch at redirect_pc
//   redirect_pc    redirect target
//   halt           HLT decoded: stop fetching until reset
//   ifid_inst      latched instruction
//   ifid_pc_plus1  PC of the latched instruction + 1
//   ifid_valid     IF/ID holds a real instruction (0 = bubble)
//   opcode         ifid_inst[15:12]
//   func_code      ifid_inst[5:0]
//   fetch_count    number of instructions loaded into IF/ID (wraps)
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = {WORD_SIZE{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic [WORD_SIZE-1:0] ifid_inst,
    output logic [WORD_SIZE-1:0] ifid_pc_plus1,
    output logic                 ifid_valid,
    output logic [3:0]           opcode,
    output logic [5:0]           func_code,
    output logic [15:0]          fetch_count
);

    // S_REQ  : request outstanding at pc
    // S_FULL : word fetched while IF/ID was stalled, parked in r_buf
    // S_DROP : waiting out a cancelled request at r_drop_addr
    // S_HALT : fetch stopped until reset
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_FULL = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t               r_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_buf;
    logic [WORD_SIZE-1:0] r_drop_addr;
    logic [WORD_SIZE-1:0] r_ifid_inst;
    logic [WORD_SIZE-1:0] r_ifid_pc_plus1;
    logic                 r_ifid_valid;
    logic [15:0]          r_fetch_count;
    logic                 r_halted;

    state_t               w_state_nxt;
    logic [WORD_SIZE-1:0] w_pc_nxt;
    logic [WORD_SIZE-1:0] w_buf_nxt;
    logic [WORD_SIZE-1:0] w_drop_addr_nxt;
    logic [WORD_SIZE-1:0] w_ifid_inst_nxt;
    logic [WORD_SIZE-1:0] w_ifid_pc_plus1_nxt;
    logic                 w_ifid_valid_nxt;
    logic [15:0]          w_fetch_count_nxt;
    logic                 w_halted_nxt;

    logic                 w_load;
    logic [WORD_SIZE-1:0] w_load_word;
    logic [WORD_SIZE-1:0] w_pc_inc;
    logic                 w_halt_any;

    // pc+1 wraps naturally at the word width.
    assign w_pc_inc   = r_pc + WORD_SIZE'(1);
    // Halt is sticky: once seen it dominates every later cycle.
    assign w_halt_any = halt | r_halted;

    // Memory request: the cancelled address is kept on the bus until the
    // memory answers it, so the handshake is never abandoned mid-flight.
    assign i_readM   = (r_state == S_REQ) || (r_state == S_DROP);
    assign i_address = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign ifid_inst     = r_ifid_inst;
    assign ifid_pc_plus1 = r_ifid_pc_plus1;
    assign ifid_valid    = r_ifid_valid;
    assign opcode        = r_ifid_inst[15:12];
    assign func_code     = r_ifid_inst[5:0];
    assign fetch_count   = r_fetch_count;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_REQ;
            r_pc            <= RESET_PC;
            r_buf           <= '0;
            r_drop_addr     <= '0;
            r_ifid_inst     <= '0;
            r_ifid_pc_plus1 <= '0;
            r_ifid_valid    <= 1'b0;
            r_fetch_count   <= '0;
            r_halted        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_buf           <= w_buf_nxt;
            r_drop_addr     <= w_drop_addr_nxt;
            r_ifid_inst     <= w_ifid_inst_nxt;
            r_ifid_pc_plus1 <= w_ifid_pc_plus1_nxt;
            r_ifid_valid    <= w_ifid_valid_nxt;
            r_fetch_count   <= w_fetch_count_nxt;
            r_halted        <= w_halted_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and IF/ID update; priority halt > redirect > stall > normal
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_buf_nxt           = r_buf;
        w_drop_addr_nxt     = r_drop_addr;
        w_ifid_inst_nxt     = r_ifid_inst;
        w_ifid_pc_plus1_nxt = r_ifid_pc_plus1;
        w_ifid_valid_nxt    = r_ifid_valid;
        w_fetch_count_nxt   = r_fetch_count;
        w_halted_nxt        = r_halted;
        w_load              = 1'b0;
        w_load_word         = r_buf;

        if (w_halt_any) begin
            w_ifid_valid_nxt = 1'b0;
            w_halted_nxt     = 1'b1;
            unique case (r_state)
                S_REQ: begin
                    if (!i_ready) begin
                        // Request still in flight: drain it before stopping.
                        w_drop_addr_nxt = r_pc;
                        w_state_nxt     = S_DROP;
                    end else begin
                        w_state_nxt = S_HALT;
                    end
                end
                S_DROP: begin
                    if (i_ready) begin
                        w_state_nxt = S_HALT;
                    end
                end
                default: w_state_nxt = S_HALT;
            endcase
        end else if (redirect) begin
            // Flush: any word returned this cycle and any parked word are lost.
            w_pc_nxt         = redirect_pc;
            w_ifid_valid_nxt = 1'b0;
            if ((r_state == S_REQ) && !i_ready) begin
                w_drop_addr_nxt = r_pc;
                w_state_nxt     = S_DROP;
            end else if ((r_state == S_DROP) && !i_ready) begin
                // Already draining: only the refetch target moves.
                w_state_nxt = S_DROP;
            end else begin
                w_state_nxt = S_REQ;
            end
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (i_ready && !stall) begin
                        w_load      = 1'b1;
                        w_load_word = i_data;
                    end else if (i_ready) begin
                        // Decode is stalled: park the word so the request
                        // can complete without disturbing IF/ID.
                        w_buf_nxt   = i_data;
                        w_state_nxt = S_FULL;
                    end else if (!stall) begin
                        w_ifid_valid_nxt = 1'b0;
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        w_load      = 1'b1;
                        w_load_word = r_buf;
                        w_state_nxt = S_REQ;
                    end
                end
                S_DROP: begin
                    w_ifid_valid_nxt = 1'b0;
                    if (i_ready) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: begin
                    w_ifid_valid_nxt = 1'b0;
                end
            endcase
        end

        if (w_load) begin
            w_ifid_inst_nxt     = w_load_word;
            w_ifid_pc_plus1_nxt = w_pc_inc;
            w_ifid_valid_nxt    = 1'b1;
            w_pc_nxt            = w_pc_inc;
            w_fetch_count_nxt   = r_fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] ifid_inst;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic [15:0] fetch_count;

  if_fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_readM      (i_readM),
    .i_address    (i_address),
    .i_data       (i_data),
    .i_ready      (i_ready),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .ifid_inst    (ifid_inst),
    .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid   (ifid_valid),
    .opcode       (opcode),
    .func_code    (func_code),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory environment
  int          lat;
  int          wait_cnt;
  bit          lat_rand;
  bit          mem_hash;
  bit          ovr_en;
  logic [15:0] ovr_addr;
  logic [15:0] ovr_val;

  // reference model: what the fetch stage should hold, in spec terms
  logic [15:0] m_pc, m_inst, m_pcp1, m_cnt, m_cancel_addr;
  bit          m_valid, m_halted, m_cancel;
  logic [15:0] m_park[$];

  typedef struct {
    bit          st;
    bit          rd;
    logic [15:0] rpc;
    bit          exp_rq;
    logic [15:0] exp_a;
    logic [15:0] exp_inst;
    logic [15:0] exp_pcp1;
    bit          exp_v;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memval(input logic [15:0] a);
    logic [15:0] h;
    if (ovr_en && a == ovr_addr) return ovr_val;
    if (mem_hash) begin
      h = (a * 16'd40503) ^ 16'h5A3C;
      return h;
    end
    return 16'h1000 + a;
  endfunction

  task automatic m_reset();
    m_pc = 16'h0000; m_inst = '0; m_pcp1 = '0; m_cnt = '0;
    m_valid = 0; m_halted = 0; m_cancel = 0; m_cancel_addr = '0;
    m_park.delete();
  endtask

  function automatic bit m_req();
    return m_cancel || (!m_halted && m_park.size() == 0);
  endfunction

  task automatic m_load(input logic [15:0] w);
    m_inst  = w;
    m_pcp1  = m_pc + 16'd1;
    m_valid = 1;
    m_pc    = m_pc + 16'd1;
    m_cnt   = m_cnt + 16'd1;
  endtask

  task automatic m_step(input bit st, input bit rd, input logic [15:0] rpc,
                        input bit hl, input bit rdy, input logic [15:0] d);
    bit req;
    req = m_req();
    if (hl || m_halted) begin
      m_halted = 1; m_valid = 0; m_park.delete();
      if (m_cancel) begin
        if (rdy) m_cancel = 0;
      end else if (req && !rdy) begin
        m_cancel = 1; m_cancel_addr = m_pc;
      end
    end else if (rd) begin
      m_valid = 0; m_park.delete();
      if (m_cancel) begin
        if (rdy) m_cancel = 0;
      end else if (req && !rdy) begin
        m_cancel = 1; m_cancel_addr = m_pc;
      end
      m_pc = rpc;
    end else if (m_cancel) begin
      m_valid = 0;
      if (rdy) m_cancel = 0;
    end else if (m_park.size() > 0) begin
      if (!st) m_load(m_park.pop_front());
    end else if (rdy && !st) begin
      m_load(d);
    end else if (rdy) begin
      m_park.push_back(d);
    end else if (!st) begin
      m_valid = 0;
    end
  endtask

  // One clock: memory answers at the negedge, control inputs driven, model
  // advanced, DUT outputs compared one step after the posedge.
  task automatic step(input bit st, input bit rd, input logic [15:0] rpc, input bit hl,
                      output bit rq_o, output logic [15:0] ad_o);
    bit          rdy;
    bit          exp_rq;
    logic [15:0] exp_ad;
    @(negedge clk);
    rq_o = i_readM;
    ad_o = i_address;
    rdy  = i_readM && (wait_cnt >= lat);
    i_ready     = rdy;
    i_data      = rdy ? memval(i_address) : 16'($urandom);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    exp_rq = m_req();
    exp_ad = m_cancel ? m_cancel_addr : m_pc;
    chk("m_readM", rq_o, exp_rq);
    if (exp_rq) chk("m_address", ad_o, exp_ad);
    m_step(st, rd, rpc, hl, rdy, i_data);
    @(posedge clk);
    #1;
    if (rq_o && !rdy) wait_cnt++;
    else begin
      wait_cnt = 0;
      if (rdy && lat_rand) lat = $urandom_range(0, 3);
    end
    chk("m_inst",   ifid_inst,     m_inst);
    chk("m_pcp1",   ifid_pc_plus1, m_pcp1);
    chk("m_valid",  ifid_valid,    m_valid);
    chk("m_count",  fetch_count,   m_cnt);
    chk("m_opcode", opcode,        m_inst[15:12]);
    chk("m_func",   func_code,     m_inst[5:0]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_inst"},  ifid_inst,     16'h0000);
    chk({tag, "_pcp1"},  ifid_pc_plus1, 16'h0000);
    chk({tag, "_valid"}, ifid_valid,    1'b0);
    chk({tag, "_count"}, fetch_count,   16'h0000);
    chk({tag, "_readM"}, i_readM,       1'b1);
    chk({tag, "_addr"},  i_address,     16'h0000);
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge.
  task automatic do_reset_async(input string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    i_ready = 0; stall = 0; redirect = 0; halt = 0;
    #1;
    check_reset_vals(tag);
    @(posedge clk);
    #2;
    reset_n  = 1'b1;
    wait_cnt = 0;
    m_reset();
  endtask

  initial begin
    bit          rq;
    logic [15:0] ad;
    int          halted_cyc;

    reset_n = 1'b0;
    i_ready = 0; i_data = '0; stall = 0; redirect = 0; redirect_pc = '0; halt = 0;
    lat = 0; wait_cnt = 0; lat_rand = 0; mem_hash = 0;
    ovr_en = 1; ovr_addr = 16'h0005; ovr_val = 16'hABCD;
    m_reset();

    #12;
    check_reset_vals("por");
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Zero-wait stream, stall with parked ABCD, redirect+stall from a parked word.
    //             st rd rpc       rq addr      inst      pcp1      v  cnt
    tbl[0]  = '{0, 0, 16'h0000, 1, 16'h0000, 16'h1000, 16'h0001, 1, 16'd1};
    tbl[1]  = '{0, 0, 16'h0000, 1, 16'h0001, 16'h1001, 16'h0002, 1, 16'd2};
    tbl[2]  = '{0, 0, 16'h0000, 1, 16'h0002, 16'h1002, 16'h0003, 1, 16'd3};
    tbl[3]  = '{0, 0, 16'h0000, 1, 16'h0003, 16'h1003, 16'h0004, 1, 16'd4};
    tbl[4]  = '{0, 0, 16'h0000, 1, 16'h0004, 16'h1004, 16'h0005, 1, 16'd5};
    tbl[5]  = '{1, 0, 16'h0000, 1, 16'h0005, 16'h1004, 16'h0005, 1, 16'd5};
    tbl[6]  = '{1, 0, 16'h0000, 0, 16'h0000, 16'h1004, 16'h0005, 1, 16'd5};
    tbl[7]  = '{0, 0, 16'h0000, 0, 16'h0000, 16'hABCD, 16'h0006, 1, 16'd6};
    tbl[8]  = '{0, 0, 16'h0000, 1, 16'h0006, 16'h1006, 16'h0007, 1, 16'd7};
    tbl[9]  = '{1, 0, 16'h0000, 1, 16'h0007, 16'h1006, 16'h0007, 1, 16'd7};
    tbl[10] = '{1, 1, 16'h0020, 0, 16'h0000, 16'h1006, 16'h0007, 0, 16'd7};
    tbl[11] = '{0, 0, 16'h0000, 1, 16'h0020, 16'h1020, 16'h0021, 1, 16'd8};
    tbl[12] = '{1, 0, 16'h0000, 1, 16'h0021, 16'h1020, 16'h0021, 1, 16'd8};
    tbl[13] = '{0, 0, 16'h0000, 0, 16'h0000, 16'h1021, 16'h0022, 1, 16'd9};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].st, tbl[i].rd, tbl[i].rpc, 1'b0, rq, ad);
      chk($sformatf("tbl%0d_readM", i), rq, tbl[i].exp_rq);
      if (tbl[i].exp_rq) chk($sformatf("tbl%0d_addr", i), ad, tbl[i].exp_a);
      chk($sformatf("tbl%0d_inst", i),  ifid_inst,     tbl[i].exp_inst);
      chk($sformatf("tbl%0d_pcp1", i),  ifid_pc_plus1, tbl[i].exp_pcp1);
      chk($sformatf("tbl%0d_valid", i), ifid_valid,    tbl[i].exp_v);
      chk($sformatf("tbl%0d_count", i), fetch_count,   tbl[i].exp_cnt);
    end
    chk("tbl_opcode_abcd_seen", {28'd0, opcode}, 32'h1);

    // Asynchronous reset mid-stream, restart at 0, then pc wrap through FFFF.
    do_reset_async("areset");
    ovr_en = 0;
    step(0, 0, 16'h0000, 0, rq, ad);
    chk("restart_addr", ad, 16'h0000);
    chk("restart_inst", ifid_inst, 16'h1000);
    step(0, 1, 16'hFFFF, 0, rq, ad);
    chk("redir_ffff_valid", ifid_valid, 1'b0);
    step(0, 0, 16'h0000, 0, rq, ad);
    chk("wrap_addr", ad, 16'hFFFF);
    chk("wrap_inst", ifid_inst, 16'h0FFF);
    chk("wrap_pcp1", ifid_pc_plus1, 16'h0000);
    step(0, 1, 16'h0008, 0, rq, ad);
    chk("wrap_next_addr", ad, 16'h0000);

    // 3-cycle latency, redirect on the 2nd wait cycle of the request at pc=8.
    lat = 3;
    step(0, 0, 16'h0000, 0, rq, ad);
    chk("lat_w0_addr", ad, 16'h0008);
    chk("lat_w0_valid", ifid_valid, 1'b0);
    step(0, 1, 16'h0040, 0, rq, ad);
    chk("lat_w1_addr", ad, 16'h0008);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 16'h0000, 0, rq, ad);
      chk($sformatf("drop%0d_readM", k), rq, 1'b1);
      chk($sformatf("drop%0d_addr", k), ad, 16'h0008);
      chk($sformatf("drop%0d_valid", k), ifid_valid, 1'b0);
    end
    chk("drop_inst_kept", ifid_inst, 16'h0FFF);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 16'h0000, 0, rq, ad);
      chk($sformatf("refetch%0d_addr", k), ad, 16'h0040);
    end
    chk("refetch_inst", ifid_inst, 16'h1040);
    chk("refetch_pcp1", ifid_pc_plus1, 16'h0041);
    chk("refetch_count", fetch_count, 16'd3);

    // Halt while a request is outstanding, then a redirect that must be ignored.
    step(0, 0, 16'h0000, 1, rq, ad);
    chk("halt_addr", ad, 16'h0041);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 16'h0000, 0, rq, ad);
      chk($sformatf("hdrop%0d_readM", k), rq, 1'b1);
      chk($sformatf("hdrop%0d_addr", k), ad, 16'h0041);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, (k == 1), 16'h0100, 0, rq, ad);
      chk($sformatf("halted%0d_readM", k), rq, 1'b0);
      chk($sformatf("halted%0d_valid", k), ifid_valid, 1'b0);
      chk($sformatf("halted%0d_count", k), fetch_count, 16'd3);
    end

    // Randomized traffic against the reference model.
    do_reset_async("rreset");
    mem_hash = 1;
    lat_rand = 1;
    lat = $urandom_range(0, 3);
    halted_cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      bit          st, rd, hl;
      logic [15:0] rpc;
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 99) < 8);
      hl  = !m_halted && ($urandom_range(0, 399) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      step(st, rd, rpc, hl, rq, ad);
      if (m_halted) halted_cyc++;
      if (halted_cyc > 12) begin
        do_reset_async("rand_reset");
        halted_cyc = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
